ternary_conv_stream: RTL and testbench

- Parametrised, streaming successor to the fixed 5x5 / two-4x4-kernel parallel ternary comparator-convolution.
- Loads CH ternary kernels (KxK, weights -1/0/+1) and an IMGxIMG signed image over valid/ready streams.
- Computes all (IMG-K+1)^2 valid-position convolutions for every channel with one time-multiplexed add/sub per channel per cycle.
- Emits results position by position on a backpressured output stream; sits between the pixel source and the pooling/activation stage.

---
 rtl/ternary_conv_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_ternary_conv_stream.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_conv_stream.sv
// ternary_conv_stream
//   Streaming ternary-weight convolution. Loads CH KxK kernels (weights -1/0/+1) and an
//   IMGxIMG signed image over valid/ready streams, then computes every valid-position
//   convolution for all channels with one add/sub per channel per cycle. Results leave
//   position by position, row-major, on a backpressured output stream.
//
//   Optional feature: define RELU_EN to clamp negative channel results to zero before
//   they are registered into out_data (timing and out_last unchanged).
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   w_valid/w_ready       weight stream handshake, w_data 2-bit code (01=+1, 11=-1, else 0)
//   w_reload              request a fresh weight load (only honoured before the first pixel)
//   pix_valid/pix_ready   pixel stream handshake, pix_data signed DW-bit pixel
//   out_valid/out_ready   result stream handshake
//   out_data              channel c in bits [c*ACC_W +: ACC_W]
//   out_last              marks the last output position of a frame
//   busy                  high while computing or emitting
module ternary_conv_stream #(
  parameter int unsigned DW    = 9,
  parameter int unsigned IMG   = 5,
  parameter int unsigned K     = 4,
  parameter int unsigned CH    = 2,
  parameter int unsigned ACC_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [1:0]            w_data,
  input  logic                  w_reload,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DW-1:0]         pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*ACC_W-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned KK   = K * K;
  localparam int unsigned NPOS = IMG - K + 1;
  localparam int unsigned NW   = CH * KK;
  localparam int unsigned NPIX = IMG * IMG;
  localparam int unsigned WAW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned PAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned KAW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned RAW  = (NPOS > 1) ? $clog2(NPOS) : 1;

  typedef enum logic [1:0] {StLoadW, StLoadPix, StCompute, StEmit} state_e;

  state_e                   state_q;
  logic [WAW-1:0]           w_cnt_q;
  logic [PAW-1:0]           pix_cnt_q;
  logic [RAW-1:0]           r_q, c_q;
  logic [KAW-1:0]           i_q, j_q;
  // Set after the last tap: the following cycle registers the result.
  logic                     wb_q;
  logic [1:0]               w_mem   [NW];
  logic signed [DW-1:0]     pix_mem [NPIX];
  logic signed [ACC_W-1:0]  acc_q   [CH];

  logic [1:0]               w_dec;
  logic [RAW-1:0]           nxt_r, nxt_c;
  logic                     pos_last;
  logic                     tap_last;
  logic [RAW-1:0]           sel_r, sel_c;
  logic [KAW-1:0]           sel_i, sel_j;
  logic [PAW-1:0]           pix_idx;
  logic signed [DW-1:0]     px;
  logic signed [ACC_W-1:0]  px_ext;
  logic signed [ACC_W-1:0]  term [CH];
  logic signed [ACC_W-1:0]  sum  [CH];

  assign w_ready   = (state_q == StLoadW);
  assign pix_ready = (state_q == StLoadPix);
  assign busy      = (state_q == StCompute) || (state_q == StEmit);

  // Reserved code 10 is stored as a zero weight.
  assign w_dec = (w_data == 2'b10) ? 2'b00 : w_data;

  function automatic logic [ACC_W-1:0] finish_sum(input logic [ACC_W-1:0] v);
`ifdef RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    pos_last = (r_q == RAW'(NPOS - 1)) && (c_q == RAW'(NPOS - 1));
    tap_last = (i_q == KAW'(K - 1)) && (j_q == KAW'(K - 1));
    if (c_q == RAW'(NPOS - 1)) begin
      nxt_c = '0;
      nxt_r = r_q + RAW'(1);
    end else begin
      nxt_c = c_q + RAW'(1);
      nxt_r = r_q;
    end

    // While a result is being accepted, tap 0 of the next position is already
    // accumulated so back-to-back positions take K*K+1 cycles.
    if (state_q == StEmit) begin
      sel_r = nxt_r;
      sel_c = nxt_c;
      sel_i = '0;
      sel_j = '0;
    end else begin
      sel_r = r_q;
      sel_c = c_q;
      sel_i = i_q;
      sel_j = j_q;
    end

    pix_idx = PAW'((32'(sel_r) + 32'(sel_i)) * IMG + 32'(sel_c) + 32'(sel_j));
    px      = pix_mem[pix_idx];
    px_ext  = ACC_W'(px);

    for (int ch = 0; ch < CH; ch++) begin
      case (w_mem[WAW'(32'(ch) * KK + 32'(sel_i) * K + 32'(sel_j))])
        2'b01:   term[ch] = px_ext;
        2'b11:   term[ch] = -px_ext;
        default: term[ch] = '0;
      endcase
      // Tap 0 restarts the sum rather than adding to the previous position.
      sum[ch] = ((sel_i == '0) && (sel_j == '0)) ? term[ch] : acc_q[ch] + term[ch];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLoadW;
      w_cnt_q   <= '0;
      pix_cnt_q <= '0;
      r_q       <= '0;
      c_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      wb_q      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int n = 0; n < NW; n++) w_mem[n] <= '0;
      for (int n = 0; n < NPIX; n++) pix_mem[n] <= '0;
      for (int ch = 0; ch < CH; ch++) acc_q[ch] <= '0;
    end else begin
      unique case (state_q)
        StLoadW: begin
          if (w_valid) begin
            w_mem[w_cnt_q] <= w_dec;
            if (w_cnt_q == WAW'(NW - 1)) begin
              w_cnt_q <= '0;
              state_q <= StLoadPix;
            end else begin
              w_cnt_q <= w_cnt_q + WAW'(1);
            end
          end
        end

        StLoadPix: begin
          // A reload request before any pixel wins over a pixel offered in the same cycle.
          if (w_reload && (pix_cnt_q == '0)) begin
            state_q <= StLoadW;
            w_cnt_q <= '0;
          end else if (pix_valid) begin
            pix_mem[pix_cnt_q] <= pix_data;
            if (pix_cnt_q == PAW'(NPIX - 1)) begin
              pix_cnt_q <= '0;
              state_q   <= StCompute;
              r_q       <= '0;
              c_q       <= '0;
              i_q       <= '0;
              j_q       <= '0;
              wb_q      <= 1'b0;
            end else begin
              pix_cnt_q <= pix_cnt_q + PAW'(1);
            end
          end
        end

        StCompute: begin
          if (wb_q) begin
            for (int ch = 0; ch < CH; ch++) begin
              out_data[ch*ACC_W +: ACC_W] <= finish_sum(acc_q[ch]);
            end
            out_valid <= 1'b1;
            out_last  <= pos_last;
            wb_q      <= 1'b0;
            state_q   <= StEmit;
          end else begin
            for (int ch = 0; ch < CH; ch++) acc_q[ch] <= sum[ch];
            if (tap_last) begin
              wb_q <= 1'b1;
              i_q  <= '0;
              j_q  <= '0;
            end else if (j_q == KAW'(K - 1)) begin
              j_q <= '0;
              i_q <= i_q + KAW'(1);
            end else begin
              j_q <= j_q + KAW'(1);
            end
          end
        end

        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (pos_last) begin
              state_q <= StLoadPix;
              r_q     <= '0;
              c_q     <= '0;
            end else begin
              r_q     <= nxt_r;
              c_q     <= nxt_c;
              state_q <= StCompute;
              i_q     <= '0;
              for (int ch = 0; ch < CH; ch++) acc_q[ch] <= sum[ch];
              if (K == 1) begin
                wb_q <= 1'b1;
                j_q  <= '0;
              end else begin
                j_q <= KAW'(1);
              end
            end
          end
        end

        default: state_q <= StLoadW;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_conv_stream.sv
// Directed bench for ternary_conv_stream with a scoreboard of expected results.
module tb_ternary_conv_stream;

  localparam int DW    = 9;
  localparam int IMG   = 5;
  localparam int K     = 4;
  localparam int CH    = 2;
  localparam int ACC_W = 14;
  localparam int KK    = K * K;
  localparam int NPOS  = IMG - K + 1;
  localparam int NW    = CH * KK;
  localparam int NPIX  = IMG * IMG;
  localparam int OW    = CH * ACC_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [1:0]    w_data = 2'b00;
  logic          w_reload = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  ternary_conv_stream #(
    .DW(DW), .IMG(IMG), .K(K), .CH(CH), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_reload(w_reload),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [1:0]    wts[NW];
  int            pix[NPIX];
  int            n_assert = 0;
  int            n_fail = 0;
  int unsigned   ref_cyc = 0;
  logic [OW-1:0] obs_data = '0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] chv(input logic [OW-1:0] d, input int ch);
    return d[ch*ACC_W +: ACC_W];
  endfunction

  function automatic logic [1:0] code(input int w);
    if (w > 0) return 2'b01;
    if (w < 0) return 2'b11;
    return 2'b00;
  endfunction

  // Direct reference convolution over the bench's own weight/pixel arrays.
  function automatic logic [OW-1:0] model(input int r, input int c);
    logic [OW-1:0] v;
    logic [1:0]    w;
    int            s;
    v = '0;
    for (int ch = 0; ch < CH; ch++) begin
      s = 0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          w = wts[ch*KK + i*K + j];
          if (w == 2'b01) s += pix[(r+i)*IMG + c + j];
          else if (w == 2'b11) s -= pix[(r+i)*IMG + c + j];
        end
      end
`ifdef RELU_EN
      if (s < 0) s = 0;
`endif
      v[ch*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return v;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < NPOS; r++) begin
      for (int c = 0; c < NPOS; c++) begin
        e.data = model(r, c);
        e.last = (r == NPOS - 1) && (c == NPOS - 1);
        sb.push_back(e);
      end
    end
  endtask

  // All send tasks start and end on a negative clock edge.
  task automatic send_w(input logic [1:0] d);
    int t;
    w_valid = 1'b1;
    w_data  = d;
    t = 0;
    while (w_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("w_ready wait", t < 50, 1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_p(input int v);
    int t;
    pix_valid = 1'b1;
    pix_data  = DW'(v);
    t = 0;
    while (pix_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("pix_ready wait", t < 50, 1);
    @(negedge clk);
    pix_valid = 1'b0;
    ref_cyc = cyc;
  endtask

  task automatic load_weights();
    for (int n = 0; n < NW; n++) send_w(wts[n]);
  endtask

  task automatic load_pixels(input int from, input int upto);
    for (int n = from; n < upto; n++) send_p(pix[n]);
  endtask

  // Waits for one result, checks it against the scoreboard, optionally stalls it.
  task automatic collect(input int hold, input int gap);
    int            t;
    exp_t          e;
    logic [OW-1:0] d0;
    logic          l0;
    if (hold > 0) out_ready = 1'b0;
    t = 0;
    while (out_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("out_valid wait", t < 200, 1);
    if (t >= 200) return;
    if (gap > 0) check("result latency", cyc - ref_cyc, gap);
    ref_cyc = cyc;
    check("scoreboard not empty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out_data", out_data, e.data);
      check("out_last", out_last, e.last);
    end
    obs_data = out_data;
    d0 = out_data;
    l0 = out_last;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("stall out_valid", out_valid, 1);
      check("stall out_data", out_data, d0);
      check("stall out_last", out_last, l0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid drop", out_valid, 0);
  endtask

  task automatic set_test1();
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        wts[i*K + j]      = ((j % 2) == 0) ? code(((i % 2) == 0) ? -1 : 1) : 2'b00;
        wts[KK + i*K + j] = (j == 1) ? code(1) : ((j == 3) ? code(-1) : 2'b00);
      end
    end
    for (int n = 0; n < NPIX; n++) pix[n] = n;
  endtask

  task automatic fill(input logic [1:0] w0, input logic [1:0] w1, input int p);
    for (int n = 0; n < KK; n++) begin
      wts[n]      = w0;
      wts[KK + n] = w1;
    end
    for (int n = 0; n < NPIX; n++) pix[n] = p;
  endtask

  task automatic reload();
    w_reload = 1'b1;
    @(negedge clk);
    w_reload = 1'b0;
    check("reload w_ready", w_ready, 1);
    check("reload pix_ready", pix_ready, 0);
  endtask

  task automatic run_frame(input int gap_first);
    push_frame();
    collect(0, gap_first);
    for (int n = 1; n < NPOS * NPOS; n++) collect(0, KK + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset w_ready", w_ready, 1);
    check("reset pix_ready", pix_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_last", out_last, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reference image
    set_test1();
    load_weights();
    check("load_pix pix_ready", pix_ready, 1);
    load_pixels(0, NPIX);
    check("compute busy", busy, 1);
    check("compute pix_ready", pix_ready, 0);
    run_frame(KK + 1);
    check("t1 ch0", chv(obs_data, 0), 20);
    check("t1 ch1", chv(obs_data, 1), -8);
    check("t1 back to load_pix", pix_ready, 1);
    check("t1 idle busy", busy, 0);

    // Backpressure on the 2nd output, weights reused
    load_pixels(0, NPIX);
    push_frame();
    collect(0, KK + 1);
    collect(5, KK + 1);
    collect(0, 0);
    collect(0, KK + 1);
    check("t4 ch0", chv(obs_data, 0), 20);
    check("t4 scoreboard drained", sb.size(), 0);

    // Reload after 3 pixels is ignored
    load_pixels(0, 3);
    w_reload = 1'b1;
    @(negedge clk);
    w_reload = 1'b0;
    check("late reload w_ready", w_ready, 0);
    check("late reload pix_ready", pix_ready, 1);
    load_pixels(3, NPIX);
    run_frame(KK + 1);
    check("t5 ch1", chv(obs_data, 1), -8);

    // Extremes after a genuine reload
    reload();
    fill(2'b11, 2'b11, -256);
    load_weights();
    load_pixels(0, NPIX);
    run_frame(KK + 1);
    check("t2a ch0", chv(obs_data, 0), 4096);
    check("t2a ch1", chv(obs_data, 1), 4096);

    reload();
    fill(2'b01, 2'b01, 255);
    load_weights();
    load_pixels(0, NPIX);
    run_frame(KK + 1);
    check("t2b ch0", chv(obs_data, 0), 4080);
    check("t2b ch1", chv(obs_data, 1), 4080);

    // Reserved code and sign of the result
    reload();
    fill(2'b10, 2'b11, 100);
    load_weights();
    load_pixels(0, NPIX);
    run_frame(KK + 1);
    check("t3 ch0", chv(obs_data, 0), 0);
`ifdef RELU_EN
    check("t3 ch1", chv(obs_data, 1), 0);
`else
    check("t3 ch1", chv(obs_data, 1), -1600);
`endif

    // Asynchronous reset during position 2
    reload();
    set_test1();
    load_weights();
    load_pixels(0, NPIX);
    push_frame();
    collect(0, KK + 1);
    collect(0, KK + 1);
    repeat (3) @(negedge clk);
    check("pre-reset busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset w_ready", w_ready, 1);
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_weights();
    load_pixels(0, NPIX);
    run_frame(KK + 1);
    check("t6 ch0", chv(obs_data, 0), 20);
    check("t6 ch1", chv(obs_data, 1), -8);
    check("final scoreboard empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
